// File: rtl/rv32i_loader_pkg.sv
// Shared types for the DMEM byte loader.
// State encoding and byte-lane width.
package rv32i_loader_pkg;

  typedef enum logic [1:0] {
    COLLECT,
    REQ,
    WAIT_ACK,
    FULL
  } state_t;

  localparam int LANE_W = 8;

endpackage

// File: rtl/dmem_byte_loader_if.sv
// Byte stream and Wishbone write bundle
// seen from the loader (master) side.
interface dmem_byte_loader_if #(
  parameter int ADDR_W = 13
) ();

  logic              i_byte_valid;
  logic [7:0]        i_byte;
  logic              o_byte_ready;
  logic              o_wb_cyc;
  logic              o_wb_stb;
  logic              o_wb_we;
  logic [ADDR_W-1:0] o_wb_addr;
  logic [31:0]       o_wb_data;
  logic [3:0]        o_wb_sel;
  logic              i_wb_ack;
  logic              i_wb_stall;

  modport master (
    input  i_byte_valid,
    input  i_byte,
    input  i_wb_ack,
    input  i_wb_stall,
    output o_byte_ready,
    output o_wb_cyc,
    output o_wb_stb,
    output o_wb_we,
    output o_wb_addr,
    output o_wb_data,
    output o_wb_sel
  );

  modport slave (
    output i_byte_valid,
    output i_byte,
    output i_wb_ack,
    output i_wb_stall,
    input  o_byte_ready,
    input  o_wb_cyc,
    input  o_wb_stb,
    input  o_wb_we,
    input  o_wb_addr,
    input  o_wb_data,
    input  o_wb_sel
  );

endinterface

// File: rtl/dmem_byte_loader.sv
// Packs a byte stream little-endian into words and
// writes each word to DMEM as a pipelined Wishbone write.
module dmem_byte_loader
  import rv32i_loader_pkg::*;
#(
  parameter  int ADDR_W    = 13,
  parameter  int BASE_ADDR = 0,
  parameter  int MAX_WORDS = 2048,
  localparam int CNT_W     = $clog2(MAX_WORDS + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_clear,
  input  logic                   i_flush,
  dmem_byte_loader_if.master     bus,
  output logic [CNT_W-1:0]       o_word_count,
  output logic                   o_busy,
  output logic                   o_full
);

  localparam logic [ADDR_W-1:0] BASE_L = ADDR_W'(BASE_ADDR);
  localparam logic [CNT_W-1:0]  MAX_L  = CNT_W'(MAX_WORDS);

  state_t              r_state;
  logic [31:0]         r_data;
  logic [3:0]          r_sel;
  logic [1:0]          r_idx;
  logic [CNT_W-1:0]    r_count;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_cyc;
  logic                r_stb;
  logic                r_busy;
  logic                r_full;
  logic                r_clr_pend;

  logic                w_accept;
  logic                w_fire;
  logic                w_done;
  logic [31:0]         w_data;
  logic [3:0]          w_sel;
  logic [CNT_W+1:0]    w_off;
  logic [ADDR_W-1:0]   w_addr;
  logic [CNT_W-1:0]    w_cnt_inc;

  assign bus.o_byte_ready = (r_state == COLLECT);
  assign bus.o_wb_cyc     = r_cyc;
  assign bus.o_wb_stb     = r_stb;
  assign bus.o_wb_we      = r_cyc;
  assign bus.o_wb_addr    = r_addr;
  assign bus.o_wb_data    = r_data;
  assign bus.o_wb_sel     = r_sel;
  assign o_word_count     = r_count;
  assign o_busy           = r_busy;
  assign o_full           = r_full;

  assign w_accept  = bus.i_byte_valid && (r_state == COLLECT);
  assign w_fire    = (w_accept && (r_idx == 2'd3))
                   || (i_flush && (w_accept || (r_idx != 2'd0)));
  assign w_off     = {r_count, 2'b00};
  assign w_addr    = BASE_L + ADDR_W'(w_off);
  assign w_cnt_inc = r_count + CNT_W'(1);
  assign w_done    = bus.i_wb_ack
                   && (((r_state == REQ) && !bus.i_wb_stall)
                      || (r_state == WAIT_ACK));

  // Merge the accepted byte into its lane of the word being built.
  always_comb begin
    w_data = r_data;
    w_sel  = r_sel;
    if (w_accept) begin
      w_data[{r_idx, 3'b000} +: LANE_W] = bus.i_byte;
      w_sel[r_idx] = 1'b1;
    end
  end

  // Loader state machine with registered bus and status outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= COLLECT;
      r_data     <= '0;
      r_sel      <= '0;
      r_idx      <= '0;
      r_count    <= '0;
      r_addr     <= '0;
      r_cyc      <= 1'b0;
      r_stb      <= 1'b0;
      r_busy     <= 1'b0;
      r_full     <= 1'b0;
      r_clr_pend <= 1'b0;
    end else begin
      unique case (r_state)
        COLLECT: begin
          if (i_clear) begin
            r_count <= '0;
            r_idx   <= '0;
            r_data  <= '0;
            r_sel   <= '0;
          end else if (w_fire) begin
            r_state <= REQ;
            r_stb   <= 1'b1;
            r_cyc   <= 1'b1;
            r_busy  <= 1'b1;
            r_addr  <= w_addr;
            r_data  <= w_data;
            r_sel   <= w_sel;
            r_idx   <= '0;
          end else if (w_accept) begin
            r_data <= w_data;
            r_sel  <= w_sel;
            r_idx  <= r_idx + 2'd1;
          end
        end
        REQ: begin
          if (i_clear) r_clr_pend <= 1'b1;
          if (!bus.i_wb_stall) begin
            r_stb   <= 1'b0;
            r_state <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (i_clear) r_clr_pend <= 1'b1;
        end
        FULL: begin
          if (i_clear) begin
            r_state <= COLLECT;
            r_full  <= 1'b0;
            r_count <= '0;
          end
        end
      endcase
      // A clear seen during the write takes effect on its ack.
      if (w_done) begin
        r_cyc      <= 1'b0;
        r_stb      <= 1'b0;
        r_busy     <= 1'b0;
        r_data     <= '0;
        r_sel      <= '0;
        r_clr_pend <= 1'b0;
        if (r_clr_pend || i_clear) begin
          r_count <= '0;
          r_state <= COLLECT;
        end else begin
          r_count <= w_cnt_inc;
          r_full  <= (w_cnt_inc == MAX_L);
          r_state <= (w_cnt_inc == MAX_L) ? FULL : COLLECT;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_byte_loader.sv
// Directed bench for dmem_byte_loader with a
// small Wishbone slave that logs accepted writes.
module tb_dmem_byte_loader;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       flush;
  logic [1:0] wcount;
  logic       busy;
  logic       full;

  int checks = 0;
  int errors = 0;

  int stall_left = 0;
  int ack_delay  = 0;
  int pend       = 0;
  int stb_cyc    = 0;
  int cyc_cyc    = 0;
  int rdy_viol   = 0;
  int log_n      = 0;
  logic [12:0] log_addr [16];
  logic [31:0] log_data [16];
  logic [3:0]  log_sel  [16];

  dmem_byte_loader_if #(.ADDR_W(13)) bus ();

  dmem_byte_loader #(
    .ADDR_W   (13),
    .BASE_ADDR(0),
    .MAX_WORDS(2)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_clear     (clear),
    .i_flush     (flush),
    .bus         (bus),
    .o_word_count(wcount),
    .o_busy      (busy),
    .o_full      (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wishbone slave: stalls on request, acks after acceptance.
  initial begin
    bus.i_wb_ack   = 1'b0;
    bus.i_wb_stall = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.i_wb_ack = 1'b0;
      if (!rst_n) begin
        pend = 0;
      end else begin
        if (bus.o_wb_cyc) cyc_cyc++;
        if (bus.o_wb_cyc && bus.o_byte_ready) rdy_viol++;
        if (pend > 0) begin
          pend--;
          if (pend == 0) bus.i_wb_ack = 1'b1;
        end
        if (bus.o_wb_stb) begin
          stb_cyc++;
          if (stall_left > 0) begin
            bus.i_wb_stall = 1'b1;
            stall_left--;
          end else begin
            bus.i_wb_stall = 1'b0;
            pend = ack_delay + 1;
            if (log_n < 16) begin
              log_addr[log_n] = bus.o_wb_addr;
              log_data[log_n] = bus.o_wb_data;
              log_sel[log_n]  = bus.o_wb_sel;
            end
            log_n++;
          end
        end else begin
          bus.i_wb_stall = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    bus.i_byte_valid = 1'b1;
    bus.i_byte       = b;
    for (int k = 0; k < 50; k++) begin
      if (bus.o_byte_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL push timeout: byte %h ready=%0b want 1", b,
               bus.o_byte_ready);
    end
    tick();
    bus.i_byte_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (!bus.o_wb_cyc) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL idle timeout: cyc=%0b want 0", bus.o_wb_cyc);
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic clr_stats();
    log_n   = 0;
    stb_cyc = 0;
    cyc_cyc = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear = 1'b0;
    flush = 1'b0;
    bus.i_byte_valid = 1'b0;
    bus.i_byte       = 8'h00;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if ({bus.o_wb_cyc, bus.o_wb_stb, bus.o_wb_we} !== 3'b000) begin
      errors++;
      $display("FAIL reset wb ctl: got %b want 000",
               {bus.o_wb_cyc, bus.o_wb_stb, bus.o_wb_we});
    end
    checks++;
    if ({bus.o_wb_addr, bus.o_wb_data, bus.o_wb_sel} !== 49'd0) begin
      errors++;
      $display("FAIL reset wb data: addr %h data %h sel %b want 0",
               bus.o_wb_addr, bus.o_wb_data, bus.o_wb_sel);
    end
    checks++;
    if ({wcount, busy, full, bus.o_byte_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL reset status: cnt %0d busy %0b full %0b rdy %0b",
               wcount, busy, full, bus.o_byte_ready);
    end
  endtask

  task automatic test_single_word();
    clr_stats();
    push(8'h11);
    push(8'h22);
    push(8'h33);
    push(8'h44);
    checks++;
    if ({bus.o_wb_stb, bus.o_wb_cyc, busy, bus.o_byte_ready}
        !== 4'b1110) begin
      errors++;
      $display("FAIL single req: stb %0b cyc %0b busy %0b rdy %0b",
               bus.o_wb_stb, bus.o_wb_cyc, busy, bus.o_byte_ready);
    end
    checks++;
    if (bus.o_wb_data !== 32'h44332211 || bus.o_wb_sel !== 4'hF
        || bus.o_wb_addr !== 13'h000 || bus.o_wb_we !== 1'b1) begin
      errors++;
      $display("FAIL single bus: addr %h data %h sel %b we %0b",
               bus.o_wb_addr, bus.o_wb_data, bus.o_wb_sel, bus.o_wb_we);
    end
    tick();
    checks++;
    if ({bus.o_wb_stb, bus.o_wb_cyc} !== 2'b01) begin
      errors++;
      $display("FAIL single wait: stb %0b cyc %0b want 0 1",
               bus.o_wb_stb, bus.o_wb_cyc);
    end
    tick();
    checks++;
    if (bus.o_byte_ready !== 1'b1 || bus.o_wb_cyc !== 1'b0
        || wcount !== 2'd1) begin
      errors++;
      $display("FAIL single done: rdy %0b cyc %0b cnt %0d want 1 0 1",
               bus.o_byte_ready, bus.o_wb_cyc, wcount);
    end
    checks++;
    if (stb_cyc != 1 || cyc_cyc != 2 || log_n != 1) begin
      errors++;
      $display("FAIL single widths: stb %0d cyc %0d wr %0d want 1 2 1",
               stb_cyc, cyc_cyc, log_n);
    end
    checks++;
    if (log_data[0] !== 32'h44332211) begin
      errors++;
      $display("FAIL single log: data %h want 44332211", log_data[0]);
    end
  endtask

  task automatic test_stall();
    pulse_clear();
    clr_stats();
    rdy_viol   = 0;
    stall_left = 3;
    for (int i = 1; i <= 8; i++) push(8'(i));
    wait_idle();
    checks++;
    if (log_n != 2 || stb_cyc != 5) begin
      errors++;
      $display("FAIL stall count: wr %0d stb %0d want 2 5",
               log_n, stb_cyc);
    end
    checks++;
    if (log_addr[0] !== 13'h000 || log_addr[1] !== 13'h004) begin
      errors++;
      $display("FAIL stall addr: %h %h want 000 004",
               log_addr[0], log_addr[1]);
    end
    checks++;
    if (log_data[0] !== 32'h04030201 || log_data[1] !== 32'h08070605) begin
      errors++;
      $display("FAIL stall data: %h %h want 04030201 08070605",
               log_data[0], log_data[1]);
    end
    checks++;
    if (rdy_viol != 0) begin
      errors++;
      $display("FAIL stall ready: %0d cycles ready in cyc want 0",
               rdy_viol);
    end
    checks++;
    if (wcount !== 2'd2 || full !== 1'b1) begin
      errors++;
      $display("FAIL stall end: cnt %0d full %0b want 2 1", wcount, full);
    end
  endtask

  task automatic test_flush();
    pulse_clear();
    clr_stats();
    push(8'hAA);
    push(8'hBB);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (bus.o_wb_stb !== 1'b1 || bus.o_wb_data !== 32'h0000BBAA
        || bus.o_wb_sel !== 4'b0011) begin
      errors++;
      $display("FAIL flush req: stb %0b data %h sel %b",
               bus.o_wb_stb, bus.o_wb_data, bus.o_wb_sel);
    end
    wait_idle();
    checks++;
    if (log_n != 1 || wcount !== 2'd1) begin
      errors++;
      $display("FAIL flush done: wr %0d cnt %0d want 1 1", log_n, wcount);
    end
    clr_stats();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (stb_cyc != 0 || cyc_cyc != 0 || wcount !== 2'd1) begin
      errors++;
      $display("FAIL flush empty: stb %0d cyc %0d cnt %0d want 0 0 1",
               stb_cyc, cyc_cyc, wcount);
    end
  endtask

  task automatic test_full();
    pulse_clear();
    clr_stats();
    for (int i = 0; i < 8; i++) push(8'(8'h21 + i));
    wait_idle();
    checks++;
    if (full !== 1'b1 || wcount !== 2'd2 || log_n != 2
        || bus.o_byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL full set: full %0b cnt %0d wr %0d rdy %0b",
               full, wcount, log_n, bus.o_byte_ready);
    end
    clr_stats();
    bus.i_byte_valid = 1'b1;
    bus.i_byte       = 8'h29;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    tick();
    checks++;
    if (stb_cyc != 0 || wcount !== 2'd2 || full !== 1'b1
        || bus.o_byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL full hold: stb %0d cnt %0d full %0b rdy %0b",
               stb_cyc, wcount, full, bus.o_byte_ready);
    end
    bus.i_byte_valid = 1'b0;
    pulse_clear();
    checks++;
    if (full !== 1'b0 || wcount !== 2'd0 || bus.o_byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL full clear: full %0b cnt %0d rdy %0b want 0 0 1",
               full, wcount, bus.o_byte_ready);
    end
    push(8'h41);
    push(8'h42);
    push(8'h43);
    push(8'h44);
    wait_idle();
    checks++;
    if (log_n != 1 || log_addr[0] !== 13'h000
        || log_data[0] !== 32'h44434241 || wcount !== 2'd1) begin
      errors++;
      $display("FAIL full next: wr %0d addr %h data %h cnt %0d",
               log_n, log_addr[0], log_data[0], wcount);
    end
  endtask

  task automatic test_clear_wait_ack();
    clr_stats();
    ack_delay = 2;
    push(8'h31);
    push(8'h32);
    push(8'h33);
    push(8'h34);
    tick();
    checks++;
    if ({bus.o_wb_stb, bus.o_wb_cyc} !== 2'b01) begin
      errors++;
      $display("FAIL clrack wait: stb %0b cyc %0b want 0 1",
               bus.o_wb_stb, bus.o_wb_cyc);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if (bus.o_wb_cyc !== 1'b1 || wcount !== 2'd1) begin
      errors++;
      $display("FAIL clrack hold: cyc %0b cnt %0d want 1 1",
               bus.o_wb_cyc, wcount);
    end
    wait_idle();
    ack_delay = 0;
    checks++;
    if (log_n != 1 || log_addr[0] !== 13'h004
        || log_data[0] !== 32'h34333231 || wcount !== 2'd0) begin
      errors++;
      $display("FAIL clrack done: wr %0d addr %h data %h cnt %0d",
               log_n, log_addr[0], log_data[0], wcount);
    end
    push(8'h51);
    push(8'h52);
    push(8'h53);
    push(8'h54);
    wait_idle();
    checks++;
    if (log_n != 2 || log_addr[1] !== 13'h000 || wcount !== 2'd1) begin
      errors++;
      $display("FAIL clrack next: wr %0d addr %h cnt %0d want 2 000 1",
               log_n, log_addr[1], wcount);
    end
  endtask

  task automatic test_reset_mid();
    stall_left = 100;
    push(8'h61);
    push(8'h62);
    push(8'h63);
    push(8'h64);
    tick();
    checks++;
    if (bus.o_wb_stb !== 1'b1) begin
      errors++;
      $display("FAIL rstmid req: stb %0b want 1", bus.o_wb_stb);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if ({bus.o_wb_cyc, bus.o_wb_stb, busy} !== 3'b000
        || wcount !== 2'd0) begin
      errors++;
      $display("FAIL rstmid drop: cyc %0b stb %0b busy %0b cnt %0d",
               bus.o_wb_cyc, bus.o_wb_stb, busy, wcount);
    end
    stall_left = 0;
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.o_byte_ready !== 1'b1 || bus.o_wb_cyc !== 1'b0) begin
      errors++;
      $display("FAIL rstmid release: rdy %0b cyc %0b want 1 0",
               bus.o_byte_ready, bus.o_wb_cyc);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_stall();
    test_flush();
    test_full();
    test_clear_wait_ack();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
